uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sampler.sv | 78 +++++++
 rtl/uart_rx_param.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: FSM state codes,
// parity encodings, frame-length limits and a parity helper.
package uart_pkg;

    localparam int MIN_DATA = 5;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_NONE1 = 2'd1,
        PAR_EVEN  = 2'd2,
        PAR_ODD   = 2'd3
    } parity_e;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;
    localparam logic [2:0] ST_WAITHI = 3'd6;

    // Expected parity bit for a right-justified word (upper bits zero).
    function automatic logic parity_exp(
        input logic [15:0] data,
        input logic        odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, oversample counter and 3-sample majority vote.
// Ports: i_rxd (async line), i_sample_tick, i_cnt_clr (hold counter at 0);
// o_rxs (synchronised line), o_voted_bit, o_mid_done (M+1 tick), o_bit_end.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_rxd,
    input  logic i_sample_tick,
    input  logic i_cnt_clr,
    output logic o_rxs,
    output logic o_voted_bit,
    output logic o_mid_done,
    output logic o_bit_end
);

    localparam int M   = OVERSAMPLE / 2;
    localparam int SCW = $clog2(OVERSAMPLE);

    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] SC_S0   = SCW'(M - 1);
    localparam logic [SCW-1:0] SC_S1   = SCW'(M);
    localparam logic [SCW-1:0] SC_S2   = SCW'(M + 1);

    logic           r_meta;
    logic           r_rxs;
    logic [SCW-1:0] r_sc;
    logic           r_s0;
    logic           r_s1;
    logic           r_s2;
    logic           w_s2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_rxs  <= 1'b1;
        end else begin
            r_meta <= i_rxd;
            r_rxs  <= r_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sc <= '0;
        end else if (i_cnt_clr) begin
            r_sc <= '0;
        end else if (i_sample_tick) begin
            r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else if (i_sample_tick) begin
            if (r_sc == SC_S0) r_s0 <= r_rxs;
            if (r_sc == SC_S1) r_s1 <= r_rxs;
            if (r_sc == SC_S2) r_s2 <= r_rxs;
        end
    end

    assign o_mid_done = i_sample_tick & (r_sc == SC_S2);
    assign o_bit_end  = i_sample_tick & (r_sc == SC_LAST);

    // On the M+1 tick itself the third sample is still on the line,
    // so the vote is already usable in that cycle.
    assign w_s2 = o_mid_done ? r_rxs : r_s2;

    assign o_voted_bit = (r_s0 & r_s1) | (r_s0 & w_s2) | (r_s1 & w_s2);
    assign o_rxs       = r_rxs;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with holding register, overrun,
// break detection and abort. Ports: config (data_bits, parity_type,
// nstop), rxd/sample_tick in, rx_data/rx_valid/rx_ready handshake,
// error flags, overrun/overrun_clr, break_detect pulse, busy.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int MAX_DATA   = 9
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                rx_en,
    input  logic                sample_tick,
    input  logic [3:0]          data_bits,
    input  logic [1:0]          parity_type,
    input  logic                nstop,
    input  logic                rxd,
    output logic [MAX_DATA-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                parity_error,
    output logic                frame_error,
    output logic                overrun,
    input  logic                overrun_clr,
    output logic                break_detect,
    output logic                busy
);

    localparam logic [3:0] MIN_W = 4'(MIN_DATA);
    localparam logic [3:0] MAX_W = 4'(MAX_DATA);

    logic [2:0]          r_state;
    logic [3:0]          r_nbits;
    logic [1:0]          r_ptype;
    logic                r_nstop;
    logic [3:0]          r_bitcnt;
    logic [MAX_DATA-1:0] r_shift;
    logic                r_perr;
    logic                r_ferr;
    logic                r_pbit;
    logic                r_stop1;
    logic [MAX_DATA-1:0] r_data;
    logic                r_valid;
    logic                r_pe;
    logic                r_fe;
    logic                r_ovr;
    logic                r_brk;

    logic       w_rxs;
    logic       w_voted;
    logic       w_mid;
    logic       w_bit_end;
    logic       w_idle;
    logic       w_start;
    logic       w_cnt_clr;
    logic [3:0] w_nbits_cfg;
    logic       w_par_en;
    logic       w_odd;
    logic       w_last_bit;
    logic [2:0] w_nxt;
    logic       w_done;
    logic       w_ferr_fin;
    logic       w_stop1_bit;
    logic       w_brk;
    logic       w_ovr_set;
    logic       w_load;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_rxd        (rxd),
        .i_sample_tick(sample_tick),
        .i_cnt_clr    (w_cnt_clr),
        .o_rxs        (w_rxs),
        .o_voted_bit  (w_voted),
        .o_mid_done   (w_mid),
        .o_bit_end    (w_bit_end)
    );

    assign w_idle    = (r_state == ST_IDLE);
    assign w_start   = w_idle & sample_tick & rx_en & ~w_rxs;
    // Counter stays at 0 in Idle; the start tick itself moves it to 1.
    assign w_cnt_clr = w_idle & ~w_start;

    assign w_nbits_cfg = (data_bits < MIN_W) ? MIN_W :
                         (data_bits > MAX_W) ? MAX_W : data_bits;

    assign w_par_en   = (r_ptype == PAR_EVEN) | (r_ptype == PAR_ODD);
    assign w_odd      = (r_ptype == PAR_ODD);
    assign w_last_bit = (r_bitcnt == r_nbits - 4'd1);

    always_comb begin
        w_nxt      = r_state;
        w_done     = 1'b0;
        w_ferr_fin = r_ferr;
        if (!w_idle && !rx_en) begin
            w_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) w_nxt = ST_START;
                end
                ST_START: begin
                    if (w_bit_end) w_nxt = w_voted ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (w_bit_end && w_last_bit)
                        w_nxt = w_par_en ? ST_PARITY : ST_STOP1;
                end
                ST_PARITY: begin
                    if (w_bit_end) w_nxt = ST_STOP1;
                end
                ST_STOP1: begin
                    if (w_mid) begin
                        w_ferr_fin = r_ferr | ~w_voted;
                        if (r_nstop) w_nxt = ST_STOP2;
                        else w_done = 1'b1;
                    end
                end
                ST_STOP2: begin
                    if (w_mid) begin
                        w_ferr_fin = r_ferr | ~w_voted;
                        w_done     = 1'b1;
                    end
                end
                ST_WAITHI: begin
                    if (sample_tick && w_rxs) w_nxt = ST_IDLE;
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
        w_stop1_bit = (r_state == ST_STOP1) ? w_voted : r_stop1;
        w_brk = w_done & (r_shift == '0) &
                (~w_par_en | ~r_pbit) & ~w_stop1_bit;
        if (w_done) w_nxt = (w_brk | w_ferr_fin) ? ST_WAITHI : ST_IDLE;
    end

    assign w_ovr_set = w_done & ~w_brk & r_valid & ~rx_ready;
    assign w_load    = w_done & ~w_brk & ~w_ovr_set;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_nbits  <= 4'd8;
            r_ptype  <= 2'd0;
            r_nstop  <= 1'b0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_pbit   <= 1'b0;
            r_stop1  <= 1'b1;
        end else begin
            r_state <= w_nxt;
            if (w_idle) begin
                r_nbits <= w_nbits_cfg;
                r_ptype <= parity_type;
                r_nstop <= nstop;
            end
            if (w_start) begin
                r_shift <= '0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
                r_pbit  <= 1'b0;
                r_stop1 <= 1'b1;
            end
            if (r_state == ST_START && w_bit_end) r_bitcnt <= '0;
            if (r_state == ST_DATA && w_bit_end) begin
                for (int i = 0; i < MAX_DATA; i++) begin
                    if (r_bitcnt == 4'(i)) r_shift[i] <= w_voted;
                end
                r_bitcnt <= r_bitcnt + 4'd1;
            end
            if (r_state == ST_PARITY && w_bit_end) begin
                r_pbit <= w_voted;
                r_perr <= w_voted ^ parity_exp(16'(r_shift), w_odd);
            end
            if (r_state == ST_STOP1 && w_mid) begin
                r_stop1 <= w_voted;
                r_ferr  <= w_ferr_fin;
            end
        end
    end

    // Holding register: flags travel with the word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
        end else if (w_load) begin
            r_data  <= r_shift;
            r_pe    <= r_perr;
            r_fe    <= w_ferr_fin;
            r_valid <= 1'b1;
        end else if (r_valid && rx_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ovr <= 1'b0;
            r_brk <= 1'b0;
        end else begin
            r_brk <= w_brk;
            if (w_ovr_set) r_ovr <= 1'b1;
            else if (overrun_clr) r_ovr <= 1'b0;
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign parity_error = r_pe;
    assign frame_error  = r_fe;
    assign overrun      = r_ovr;
    assign break_detect = r_brk;
    assign busy         = ~w_idle;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_param;

    localparam int OS = 16;
    localparam int MD = 9;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          rx_en;
    logic          sample_tick;
    logic [3:0]    data_bits;
    logic [1:0]    parity_type;
    logic          nstop;
    logic          rxd;
    logic [MD-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          parity_error;
    logic          frame_error;
    logic          overrun;
    logic          overrun_clr;
    logic          break_detect;
    logic          busy;

    typedef struct packed {
        logic [MD-1:0] d;
        logic          pe;
        logic          fe;
    } word_t;

    int    errors = 0;
    int    checks = 0;
    int    brk_cnt = 0;
    word_t got_q[$];

    always #5 clock = ~clock;

    uart_rx_param #(
        .OVERSAMPLE(OS),
        .MAX_DATA  (MD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_en       (rx_en),
        .sample_tick (sample_tick),
        .data_bits   (data_bits),
        .parity_type (parity_type),
        .nstop       (nstop),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_error(parity_error),
        .frame_error (frame_error),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .break_detect(break_detect),
        .busy        (busy)
    );

    // Passive monitor: records every accepted word and break pulse.
    always @(negedge clock) begin
        if (reset_n && rx_valid && rx_ready)
            got_q.push_back({rx_data, parity_error, frame_error});
        if (break_detect) brk_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic line_idle(input int n);
        rxd = 1'b1;
        cycles(n);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        cycles(OS);
    endtask

    // Drives one frame; rdy_pulse raises rx_ready for exactly the
    // clock edge on which the first stop bit's middle sample lands.
    task automatic send_frame(
        input logic [MD-1:0] d,
        input int            nb,
        input logic [1:0]    pt,
        input logic          ns,
        input logic          flip,
        input logic          s1,
        input logic          s2,
        input logic          rdy_pulse
    );
        logic p;
        data_bits   = 4'(nb);
        parity_type = pt;
        nstop       = ns;
        p           = pt[0] ^ flip;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) begin
            send_bit(d[i]);
            p = p ^ d[i];
        end
        if (pt[1]) send_bit(p);
        rxd = s1;
        if (rdy_pulse) begin
            cycles(11);
            rx_ready = 1'b1;
            cycles(1);
            rx_ready = 1'b0;
            cycles(OS - 12);
        end else begin
            cycles(OS);
        end
        if (ns) send_bit(s2);
    endtask

    task automatic chk_out_zero(input string tag);
        checks++;
        if (rx_data !== '0 || rx_valid !== 1'b0 || parity_error !== 1'b0 ||
            frame_error !== 1'b0 || overrun !== 1'b0 ||
            break_detect !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got data=%0h v=%b pe=%b fe=%b ov=%b brk=%b busy=%b expected all 0",
                     tag, rx_data, rx_valid, parity_error, frame_error,
                     overrun, break_detect, busy);
        end
    endtask

    task automatic chk_word(input string tag, input int idx, input word_t exp);
        checks++;
        if (got_q.size() != idx + 1) begin
            errors++;
            $display("FAIL %s_count: got %0d words expected %0d",
                     tag, got_q.size(), idx + 1);
        end else begin
            checks++;
            if (got_q[idx] !== exp) begin
                errors++;
                $display("FAIL %s_word: got d=%0h pe=%b fe=%b expected d=%0h pe=%b fe=%b",
                         tag, got_q[idx].d, got_q[idx].pe, got_q[idx].fe,
                         exp.d, exp.pe, exp.fe);
            end
        end
    endtask

    task automatic chk_bit(input string tag, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic test_reset;
        cycles(2);
        chk_out_zero("reset");
        reset_n = 1'b1;
        line_idle(5);
        chk_out_zero("post_reset");
    endtask

    task automatic test_8n1;
        int rd = got_q.size();
        send_frame(9'h0A5, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_bit("8n1_busy", busy, 1'b0);
        chk_word("8n1", rd, {9'h0A5, 1'b0, 1'b0});
        chk_bit("8n1_valid_fall", rx_valid, 1'b0);
        line_idle(8);
    endtask

    task automatic test_parity;
        int rd = got_q.size();
        send_frame(9'h035, 7, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_word("7e2_bad", rd, {9'h035, 1'b1, 1'b0});
        line_idle(8);
        send_frame(9'h1FF, 9, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_word("9o1", rd + 1, {9'h1FF, 1'b0, 1'b0});
        line_idle(8);
    endtask

    task automatic test_frame_error;
        int rd = got_q.size();
        int b0 = brk_cnt;
        send_frame(9'h03C, 8, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycles(3 * OS);
        chk_bit("ferr_waithigh_busy", busy, 1'b1);
        chk_word("ferr", rd, {9'h03C, 1'b0, 1'b1});
        chk_int("ferr_no_break", brk_cnt, b0);
        line_idle(5);
        chk_bit("ferr_release_busy", busy, 1'b0);
        line_idle(3 * OS);
        chk_int("ferr_no_retrigger", got_q.size(), rd + 1);
    endtask

    task automatic test_overrun;
        rx_ready = 1'b0;
        send_frame(9'h011, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        line_idle(4);
        send_frame(9'h022, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        line_idle(4);
        chk_bit("ovr_valid", rx_valid, 1'b1);
        chk_int("ovr_held", int'(rx_data), 'h11);
        chk_bit("ovr_set", overrun, 1'b1);
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;
        chk_bit("ovr_clr", overrun, 1'b0);
        send_frame(9'h022, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_bit("simul_valid", rx_valid, 1'b1);
        chk_int("simul_data", int'(rx_data), 'h22);
        chk_bit("simul_no_ovr", overrun, 1'b0);
        rx_ready = 1'b1;
        line_idle(4);
        chk_bit("ovr_drained", rx_valid, 1'b0);
    endtask

    task automatic test_glitch;
        int rd = got_q.size();
        int b0 = brk_cnt;
        rxd = 1'b0;
        cycles(4);
        line_idle(8);
        chk_bit("glitch_in_start", busy, 1'b1);
        line_idle(20);
        chk_bit("glitch_idle", busy, 1'b0);
        chk_int("glitch_no_word", got_q.size(), rd);
        chk_int("glitch_no_break", brk_cnt, b0);
    endtask

    task automatic test_break;
        int rd = got_q.size();
        int b0 = brk_cnt;
        data_bits   = 4'd8;
        parity_type = 2'd2;
        nstop       = 1'b0;
        rxd = 1'b0;
        cycles(12 * OS);
        chk_int("break_pulse", brk_cnt, b0 + 1);
        chk_int("break_no_word", got_q.size(), rd);
        chk_bit("break_valid", rx_valid, 1'b0);
        chk_bit("break_waithigh", busy, 1'b1);
        line_idle(5);
        chk_bit("break_release", busy, 1'b0);
        line_idle(OS);
    endtask

    task automatic test_abort;
        int rd = got_q.size();
        data_bits   = 4'd8;
        parity_type = 2'd0;
        nstop       = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rxd = 1'b1;
        cycles(8);
        chk_bit("abort_busy_before", busy, 1'b1);
        rx_en = 1'b0;
        cycles(1);
        chk_bit("abort_idle", busy, 1'b0);
        rxd = 1'b1;
        cycles(4);
        rx_en = 1'b1;
        line_idle(3 * OS);
        chk_int("abort_no_word", got_q.size(), rd);
        chk_bit("abort_no_valid", rx_valid, 1'b0);
    endtask

    // Reference model: a frame yields a break when data, parity (if any)
    // and first stop are all 0; otherwise one word with the flags below.
    task automatic test_random;
        int rd = got_q.size();
        int eb = brk_cnt;
        for (int n = 0; n < 24; n++) begin
            int            nb = int'($urandom_range(5, MD));
            logic [1:0]    pt = 2'($urandom_range(0, 3));
            logic          ns = 1'($urandom_range(0, 1));
            logic          fl = ($urandom_range(0, 3) == 0);
            logic          s1 = ($urandom_range(0, 5) != 0);
            logic          s2 = ($urandom_range(0, 5) != 0);
            logic [MD-1:0] d  = MD'($urandom);
            logic          p;
            logic          brk;
            logic          fe;
            for (int i = nb; i < MD; i++) d[i] = 1'b0;
            if ($urandom_range(0, 7) == 0) d = '0;
            p   = pt[0] ^ fl ^ (^d);
            fe  = ~s1 | (ns & ~s2);
            brk = (d == '0) && (!pt[1] || !p) && !s1;
            send_frame(d, nb, pt, ns, fl, s1, s2, 1'b0);
            if (brk) begin
                eb++;
                chk_int("rnd_break", brk_cnt, eb);
                chk_int("rnd_break_no_word", got_q.size(), rd);
            end else begin
                chk_word("rnd", rd, {d, pt[1] & fl, fe});
                rd++;
            end
            if (brk || fe) line_idle(20 + int'($urandom_range(0, 10)));
            else line_idle(int'($urandom_range(0, 10)));
        end
        chk_int("rnd_total_breaks", brk_cnt, eb);
    endtask

    task automatic test_reset_mid;
        rx_ready = 1'b0;
        send_frame(9'h05A, 8, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        line_idle(4);
        chk_bit("rstmid_held", rx_valid, 1'b1);
        rxd = 1'b0;
        cycles(20);
        #3;
        reset_n = 1'b0;
        #1;
        chk_out_zero("reset_async");
        rxd = 1'b1;
        cycles(2);
        reset_n  = 1'b1;
        rx_ready = 1'b1;
        line_idle(4);
        chk_out_zero("reset_release");
    endtask

    initial begin
        reset_n     = 1'b0;
        rx_en       = 1'b1;
        sample_tick = 1'b1;
        data_bits   = 4'd8;
        parity_type = 2'd0;
        nstop       = 1'b0;
        rxd         = 1'b1;
        rx_ready    = 1'b1;
        overrun_clr = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_frame_error();
        test_overrun();
        test_glitch();
        test_break();
        test_abort();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
